puf_resp_collect: RTL and testbench

Parametrised PUF response collector. It expands one W-bit challenge into an N_WORDS×W-bit device response. For each word it steps an external challenge LFSR, waits for the PUF core to settle, samples the core VOTES times and takes a bitwise majority. It sits between the challenge LFSR, the PUF core and the key/ID consumer, and adds a start/busy handshake, re-triggering and an instability count.

---
 rtl/puf_resp_collect.sv | 152 +++++++++++++++
 tb/tb_puf_resp_collect.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_collect.sv
// PUF response collector: steps an external challenge LFSR, majority-votes each
// PUF word over VOTES samples and assembles an N_WORDS x W response.
module puf_resp_collect #(
    parameter int unsigned W       = 16,
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned VOTES   = 3,
    parameter int unsigned SETTLE  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [W-1:0]                       challenge,
    output logic                               lfsr_load,
    output logic [W-1:0]                       seed_out,
    output logic                               lfsr_step,
    input  logic                               lfsr_ready,
    input  logic [W-1:0]                       puf_data,
    output logic [W*N_WORDS-1:0]               resp,
    output logic                               resp_valid,
    output logic                               busy,
    output logic [$clog2(W*N_WORDS+1)-1:0]     unstable_cnt
);

    localparam int unsigned RW = W * N_WORDS;
    localparam int unsigned UW = $clog2(RW + 1);
    localparam int unsigned CW = $clog2(VOTES + 1);
    localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitRdy,
        StSettle,
        StSample,
        StCommit
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    seed_q;
    logic [RW-1:0]   resp_q;
    logic            resp_valid_q;
    logic [UW-1:0]   unstable_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   vote_cnt_q;
    logic [SW-1:0]   settle_cnt_q;
    logic [CW-1:0]   votes_q [W];

    logic            last_word;
    logic            vote_last;
    logic            settle_last;
    logic [W-1:0]    word;
    logic [UW-1:0]   unstable_word;

    assign last_word   = (idx_q == IW'(N_WORDS - 1));
    assign vote_last   = (vote_cnt_q == CW'(VOTES - 1));
    assign settle_last = (32'(settle_cnt_q) + 32'd1 >= SETTLE);

    // Majority per bit; a bit is unstable unless all votes agreed.
    always_comb begin
        word          = '0;
        unstable_word = '0;
        for (int i = 0; i < int'(W); i++) begin
            word[i] = (votes_q[i] > CW'(VOTES / 2));
            if (votes_q[i] != '0 && votes_q[i] != CW'(VOTES)) begin
                unstable_word = unstable_word + UW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StLoad;
            StLoad:    state_d = StWaitRdy;
            StWaitRdy: if (lfsr_ready) state_d = (SETTLE == 0) ? StSample : StSettle;
            StSettle:  if (settle_last) state_d = StSample;
            StSample: begin
                if (vote_last)         state_d = StCommit;
                else if (SETTLE == 0)  state_d = StSample;
                else                   state_d = StSettle;
            end
            StCommit:  state_d = last_word ? StIdle : StWaitRdy;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q       <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            unstable_q   <= '0;
            idx_q        <= '0;
            vote_cnt_q   <= '0;
            settle_cnt_q <= '0;
            for (int i = 0; i < int'(W); i++) votes_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        seed_q       <= challenge;
                        resp_valid_q <= 1'b0;
                        unstable_q   <= '0;
                        idx_q        <= '0;
                    end
                end
                StSettle: begin
                    settle_cnt_q <= settle_last ? '0 : settle_cnt_q + SW'(1);
                end
                StSample: begin
                    for (int i = 0; i < int'(W); i++) begin
                        votes_q[i] <= votes_q[i] + CW'(puf_data[i]);
                    end
                    vote_cnt_q <= vote_cnt_q + CW'(1);
                end
                StCommit: begin
                    // Word 0 lands in the MSBs.
                    for (int k = 0; k < int'(N_WORDS); k++) begin
                        if (idx_q == IW'(int'(N_WORDS) - 1 - k)) resp_q[k*W +: W] <= word;
                    end
                    unstable_q <= unstable_q + unstable_word;
                    vote_cnt_q <= '0;
                    for (int i = 0; i < int'(W); i++) votes_q[i] <= '0;
                    if (last_word) begin
                        resp_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign lfsr_load    = (state_q == StLoad);
    assign lfsr_step    = (state_q == StCommit) && !last_word;
    assign seed_out     = seed_q;
    assign resp         = resp_q;
    assign resp_valid   = resp_valid_q;
    assign unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_resp_collect.sv
// Directed bench for puf_resp_collect: default configuration driven by an LFSR/PUF
// model with per-vote data, plus a W=8/N_WORDS=2/VOTES=1/SETTLE=0 instance.
module tb_puf_resp_collect;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, lfsr_ready;
    logic [15:0]  challenge, puf_data;
    logic         lfsr_load, lfsr_step, resp_valid, busy;
    logic [15:0]  seed_out;
    logic [127:0] resp;
    logic [7:0]   unstable_cnt;

    logic         start2, ready2;
    logic [7:0]   chal2, puf2;
    logic         load2, step2, valid2, busy2;
    logic [7:0]   seed2;
    logic [15:0]  resp2;
    logic [4:0]   unst2;

    int cyc = 0;
    int n_load = 0;
    int n_step = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (lfsr_load) n_load++;
        if (lfsr_step) n_step++;
    end

    puf_resp_collect dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .lfsr_load(lfsr_load), .seed_out(seed_out), .lfsr_step(lfsr_step),
        .lfsr_ready(lfsr_ready), .puf_data(puf_data), .resp(resp),
        .resp_valid(resp_valid), .busy(busy), .unstable_cnt(unstable_cnt)
    );

    puf_resp_collect #(.W(8), .N_WORDS(2), .VOTES(1), .SETTLE(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .challenge(chal2),
        .lfsr_load(load2), .seed_out(seed2), .lfsr_step(step2),
        .lfsr_ready(ready2), .puf_data(puf2), .resp(resp2),
        .resp_valid(valid2), .busy(busy2), .unstable_cnt(unst2)
    );

    typedef struct {
        int           delay;
        bit           by_word;
        bit           toggle;
        logic [15:0]  chal, v0, v1, v2;
        logic [127:0] exp_resp;
        int           exp_unst;
        int           exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int e0, t, l0, s0;
        logic [15:0] d;
        l0 = n_load;
        s0 = n_step;
        @(negedge clk);
        challenge = v.chal;
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_run"}, 128'(busy), 128'(1));
        check({tag, "_valid_clr"}, 128'(resp_valid), 128'(0));
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!(lfsr_load || lfsr_step) && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                check({tag, "_pulse_timeout"}, 128'(1), 128'(0));
                return;
            end
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                if (v.toggle) begin
                    start = ~start;
                    challenge = 16'($urandom);
                end
            end
            @(negedge clk);
            start = 1'b0;
            lfsr_ready = 1'b1;
            d = v.by_word ? 16'(16'h1111 * (k + 1)) : v.v0;
            puf_data = d;
            @(negedge clk);
            lfsr_ready = 1'b0;
            repeat (3) @(negedge clk);
            if (!v.by_word) puf_data = v.v1;
            repeat (3) @(negedge clk);
            if (!v.by_word) puf_data = v.v2;
        end
        t = 0;
        while (!resp_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_latency"}, 128'(cyc - e0), 128'(v.exp_lat));
        check({tag, "_resp"}, resp, v.exp_resp);
        check({tag, "_unstable"}, 128'(unstable_cnt), 128'(v.exp_unst));
        check({tag, "_seed"}, 128'(seed_out), 128'(v.chal));
        check({tag, "_busy_done"}, 128'(busy), 128'(0));
        check({tag, "_loads"}, 128'(n_load - l0), 128'(1));
        check({tag, "_steps"}, 128'(n_step - s0), 128'(7));
        repeat (3) @(negedge clk);
        check({tag, "_valid_hold"}, 128'({resp_valid, busy}), 128'(2'b10));
    endtask

    initial begin
        int e0, t;
        vecs[0] = '{0, 1'b0, 1'b0, 16'h1234, 16'hA5C3, 16'hA5C3, 16'hA5C3,
                    {8{16'hA5C3}}, 0, 89};
        vecs[1] = '{0, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF,
                    {8{16'hFFFF}}, 128, 89};
        vecs[2] = '{0, 1'b0, 1'b0, 16'hC0DE, 16'h0F0F, 16'h0F0F, 16'hF0F0,
                    {8{16'h0F0F}}, 128, 89};
        vecs[3] = '{0, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0000, 16'h0000,
                    {16'h1111, 16'h2222, 16'h3333, 16'h4444,
                     16'h5555, 16'h6666, 16'h7777, 16'h8888}, 0, 89};
        vecs[4] = '{5, 1'b0, 1'b1, 16'h9AB1, 16'h5A3C, 16'h5A3C, 16'h5A3C,
                    {8{16'h5A3C}}, 0, 129};

        rst = 1'b1;
        start = 1'b0; lfsr_ready = 1'b0; challenge = '0; puf_data = '0;
        start2 = 1'b0; ready2 = 1'b0; chal2 = '0; puf2 = 8'h3C;
        repeat (2) @(negedge clk);
        check("reset_outs", 128'({resp_valid, busy, lfsr_load, lfsr_step}), 128'(0));
        check("reset_regs", {resp, seed_out, unstable_cnt}, 128'(0));
        check("reset_dut2", 128'({resp2, valid2, busy2, seed2, unst2}), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a run, then a clean run.
        @(negedge clk);
        challenge = 16'hBEEF;
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        lfsr_ready = 1'b1;
        puf_data = 16'h00FF;
        @(negedge clk);
        lfsr_ready = 1'b0;
        t = 0;
        while (cyc < e0 + 40 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("midrst_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("midrst_outs", 128'({resp_valid, busy, lfsr_load, lfsr_step}), 128'(0));
        check("midrst_regs", {resp, seed_out, unstable_cnt}, 128'(0));
        @(negedge clk);
        check("midrst_hold", 128'({busy, resp_valid}), 128'(0));
        rst = 1'b0;
        run_one(vecs[0], "after_rst");

        // Minimal configuration on the second instance.
        @(negedge clk);
        chal2 = 8'h5D;
        start2 = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!(load2 || step2) && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            ready2 = 1'b1;
            @(negedge clk);
            ready2 = 1'b0;
        end
        t = 0;
        while (!valid2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("small_latency", 128'(cyc - e0), 128'(7));
        check("small_resp", 128'(resp2), 128'(16'h3C3C));
        check("small_unstable", 128'(unst2), 128'(0));
        check("small_seed", 128'(seed2), 128'(8'h5D));
        check("small_busy", 128'(busy2), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
